// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point add/subtract with valid/ready handshake.
// An input capture rank followed by align, add and normalise/round stages;
// a single global stall freezes every rank while the result is held.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int DW    = EXP_W + MAN_W + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_1,
  input  logic [DW-1:0] data_2,
  input  logic          op_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_o,
  output logic [2:0]    flags_o
);

  // Aligned mantissa layout: {hidden, fraction, guard, round, sticky}
  localparam int MW = MAN_W + 4;
  // Working exponent carries a sign bit and one headroom bit
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0]    E_ONE    = EW'(1);
  localparam logic [31:0]      SH_MAX   = 32'(MAN_W + 3);

  // Leading-zero count of the un-carried sum
  function automatic logic [EW-1:0] lzc(input logic [MW-1:0] v);
    logic [EW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + E_ONE;
      end else begin
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic stall_s, en_s;
  logic out_valid_q;
  logic [DW-1:0] data_q, data_d;
  logic [2:0]    flags_q, flags_d;

  assign stall_s   = out_valid_q & ~out_ready;
  assign en_s      = ~stall_s;
  assign in_ready  = ~stall_s;
  assign out_valid = out_valid_q;
  assign data_o    = data_q;
  assign flags_o   = flags_q;

  // ---------------- rank 0: operand capture ----------------
  logic          v0_q, op_q;
  logic [DW-1:0] a_q, b_q;

  // Capture operands only on an input transfer; valid advances unless stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 1'b0;
    end else if (en_s) begin
      v0_q <= in_valid;
      if (in_valid) begin
        a_q  <= data_1;
        b_q  <= data_2;
        op_q <= op_sel;
      end
    end
  end

  // ---------------- stage 1: unpack / swap / align ----------------
  logic sa_s, sb_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s, swap_s;
  logic [EXP_W-1:0] ea_s, eb_s, exp_l_s, exp_sm_s, diff_s;
  logic [MAN_W-1:0] fa_eff_s, fb_eff_s;
  logic [MW-1:0]    ml_s, ms_s, aligned_s;
  logic [31:0]      diff32_s, sh_s;
  logic             sign_l_s, sign_sm_s, lost_s;
  logic             nan_s, inv_s, inf_s, infs_s;

  assign sa_s     = a_q[DW-1];
  assign sb_s     = b_q[DW-1] ^ op_q;
  assign ea_s     = a_q[DW-2:MAN_W];
  assign eb_s     = b_q[DW-2:MAN_W];
  assign a_zero_s = (ea_s == '0);
  assign b_zero_s = (eb_s == '0);
  assign a_inf_s  = (ea_s == EXP_ONES) && (a_q[MAN_W-1:0] == '0);
  assign b_inf_s  = (eb_s == EXP_ONES) && (b_q[MAN_W-1:0] == '0);
  assign a_nan_s  = (ea_s == EXP_ONES) && (a_q[MAN_W-1:0] != '0);
  assign b_nan_s  = (eb_s == EXP_ONES) && (b_q[MAN_W-1:0] != '0);
  assign fa_eff_s = a_zero_s ? '0 : a_q[MAN_W-1:0];
  assign fb_eff_s = b_zero_s ? '0 : b_q[MAN_W-1:0];
  assign swap_s   = {eb_s, fb_eff_s} > {ea_s, fa_eff_s};

  // Order operands by magnitude and right-shift the smaller with sticky collection
  always_comb begin
    sign_l_s  = 1'b0;
    sign_sm_s = 1'b0;
    exp_l_s   = '0;
    exp_sm_s  = '0;
    ml_s      = '0;
    ms_s      = '0;
    if (swap_s) begin
      sign_l_s  = sb_s;
      exp_l_s   = eb_s;
      ml_s      = {~b_zero_s, fb_eff_s, 3'b000};
      sign_sm_s = sa_s;
      exp_sm_s  = ea_s;
      ms_s      = {~a_zero_s, fa_eff_s, 3'b000};
    end else begin
      sign_l_s  = sa_s;
      exp_l_s   = ea_s;
      ml_s      = {~a_zero_s, fa_eff_s, 3'b000};
      sign_sm_s = sb_s;
      exp_sm_s  = eb_s;
      ms_s      = {~b_zero_s, fb_eff_s, 3'b000};
    end
    diff_s    = exp_l_s - exp_sm_s;
    diff32_s  = {{(32-EXP_W){1'b0}}, diff_s};
    // Beyond MAN_W+3 every bit of the smaller operand lands in sticky
    sh_s      = (diff32_s >= SH_MAX) ? SH_MAX : diff32_s;
    lost_s    = |(ms_s & ~({MW{1'b1}} << sh_s));
    aligned_s = (ms_s >> sh_s) | {{(MW-1){1'b0}}, lost_s};
  end

  // Special-operand classification; NaN dominates, then effective Inf-Inf
  always_comb begin
    nan_s  = a_nan_s | b_nan_s | (a_inf_s & b_inf_s & (sa_s ^ sb_s));
    inv_s  = a_inf_s & b_inf_s & (sa_s ^ sb_s) & ~(a_nan_s | b_nan_s);
    inf_s  = (a_inf_s | b_inf_s) & ~nan_s;
    infs_s = a_inf_s ? sa_s : sb_s;
  end

  logic             v1_q, sign1_q, sub1_q, zs1_q, nan1_q, inv1_q, inf1_q, infs1_q;
  logic [EXP_W-1:0] exp1_q;
  logic [MW-1:0]    ml1_q, ms1_q;

  // Stage-1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; sign1_q <= 1'b0; sub1_q <= 1'b0; zs1_q <= 1'b0;
      nan1_q <= 1'b0; inv1_q <= 1'b0; inf1_q <= 1'b0; infs1_q <= 1'b0;
      exp1_q <= '0; ml1_q <= '0; ms1_q <= '0;
    end else if (en_s) begin
      v1_q    <= v0_q;
      sign1_q <= sign_l_s;
      sub1_q  <= sign_l_s ^ sign_sm_s;
      zs1_q   <= sa_s & sb_s;
      nan1_q  <= nan_s;
      inv1_q  <= inv_s;
      inf1_q  <= inf_s;
      infs1_q <= infs_s;
      exp1_q  <= exp_l_s;
      ml1_q   <= ml_s;
      ms1_q   <= aligned_s;
    end
  end

  // ---------------- stage 2: magnitude add / subtract ----------------
  logic             v2_q, sign2_q, zs2_q, nan2_q, inv2_q, inf2_q, infs2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [MW:0]      sum2_q;

  // Stage-2 register; larger magnitude is first so the difference is never negative
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0; sign2_q <= 1'b0; zs2_q <= 1'b0; nan2_q <= 1'b0;
      inv2_q <= 1'b0; inf2_q <= 1'b0; infs2_q <= 1'b0; exp2_q <= '0; sum2_q <= '0;
    end else if (en_s) begin
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      zs2_q   <= zs1_q;
      nan2_q  <= nan1_q;
      inv2_q  <= inv1_q;
      inf2_q  <= inf1_q;
      infs2_q <= infs1_q;
      exp2_q  <= exp1_q;
      sum2_q  <= sub1_q ? ({1'b0, ml1_q} - {1'b0, ms1_q}) : ({1'b0, ml1_q} + {1'b0, ms1_q});
    end
  end

  // ---------------- stage 3: normalise / round / pack ----------------
  logic [MW-1:0]    norm_s;
  logic [EW-1:0]    lz_s, e_s, e_r_s;
  logic [MAN_W+1:0] mant_s;
  logic [MAN_W-1:0] frac_s;
  logic             g_s, r_s, st_s, rnd_s;

  // Normalise, round to nearest even, then apply zero/underflow/overflow/special overrides
  always_comb begin
    norm_s = '0;
    lz_s   = '0;
    e_s    = '0;
    if (sum2_q[MW]) begin
      norm_s = {sum2_q[MW:2], sum2_q[1] | sum2_q[0]};
      e_s    = {2'b00, exp2_q} + E_ONE;
    end else begin
      lz_s   = lzc(sum2_q[MW-1:0]);
      norm_s = sum2_q[MW-1:0] << lz_s;
      e_s    = {2'b00, exp2_q} - lz_s;
    end
    g_s    = norm_s[2];
    r_s    = norm_s[1];
    st_s   = norm_s[0];
    rnd_s  = g_s & (r_s | st_s | norm_s[3]);
    mant_s = {1'b0, norm_s[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_s};
    e_r_s  = mant_s[MAN_W+1] ? (e_s + E_ONE) : e_s;
    frac_s = mant_s[MAN_W+1] ? mant_s[MAN_W:1] : mant_s[MAN_W-1:0];

    data_d  = '0;
    flags_d = 3'b000;
    if (nan2_q) begin
      data_d  = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d = {inv2_q, 2'b00};
    end else if (inf2_q) begin
      data_d  = {infs2_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 3'b000;
    end else if (sum2_q == '0) begin
      data_d  = {zs2_q, {(DW-1){1'b0}}};
      flags_d = 3'b000;
    end else if (e_s[EW-1] || (e_s == '0)) begin
      data_d  = {sign2_q, {(DW-1){1'b0}}};
      flags_d = 3'b001;
    end else if (!e_r_s[EW-1] && (e_r_s[EXP_W:0] >= {1'b0, EXP_ONES})) begin
      data_d  = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 3'b011;
    end else begin
      data_d  = {sign2_q, e_r_s[EXP_W-1:0], frac_s};
      flags_d = {2'b00, g_s | r_s | st_s};
    end
  end

  // Output register; holds while stalled so the consumer sees stable data
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      flags_q     <= 3'b000;
    end else if (en_s) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        data_q  <= data_d;
        flags_q <= flags_d;
      end
    end
  end

endmodule
